// File: rtl/router_pkg.sv
// Shared constants and the framer state type for the router packet framer.
package router_pkg;

   localparam int unsigned DEST_W    = 2;
   localparam int unsigned LEN_W     = 6;
   localparam int unsigned NUM_PORTS = 3;
   localparam logic [DEST_W-1:0] DEST_INVALID = 2'd3;
   localparam int unsigned MAX_LEN   = 63;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      HEADER,
      PAYLOAD,
      PARITY
   } framer_state_e;

endpackage

// File: rtl/framer_buf.sv
// Payload buffer for the framer: 64x8, synchronous write, combinational read, no reset.
module framer_buf
   import router_pkg::*;
(
   input  logic             clock,
   input  logic             wr_en,
   input  logic [LEN_W-1:0] wr_addr,
   input  logic [7:0]       wr_data,
   input  logic [LEN_W-1:0] rd_addr,
   output logic [7:0]       rd_data
);

   logic [7:0] mem [MAX_LEN+1];

   always_ff @(posedge clock) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/router_pkt_framer.sv
// Buffers a payload then emits header, payload and parity bytes to the router.
// Optional FRAMER_ERR_INJECT_EN adds inject_err to corrupt the parity byte's LSB.
module router_pkt_framer
   import router_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [DEST_W-1:0] cmd_dest,
   input  logic [LEN_W-1:0]  cmd_len,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   input  logic              busy,
`ifdef FRAMER_ERR_INJECT_EN
   input  logic              inject_err,
`endif
   output logic              pkt_valid,
   output logic [7:0]        data_out,
   output logic              done,
   output logic              cmd_err
);

   framer_state_e     state_q, state_d;
   logic [DEST_W-1:0] dest_q, dest_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [LEN_W-1:0]  cnt_q, cnt_d;
   logic [7:0]        par_q, par_d;
   logic              inj_q, inj_d;
   logic              pkt_valid_d, done_d, cmd_err_d;
   logic [7:0]        data_out_d;
   logic              wr_en;
   logic [LEN_W-1:0]  rd_addr;
   logic [7:0]        rd_data;
   logic              cmd_ok;
   logic              last_byte;

   framer_buf u_buf (
      .clock   (clock),
      .wr_en   (wr_en),
      .wr_addr (cnt_q),
      .wr_data (in_data),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   assign cmd_ready = (state_q == IDLE);
   assign in_ready  = (state_q == LOAD);
   assign cmd_ok    = (cmd_dest != DEST_INVALID) && (32'(cmd_dest) < NUM_PORTS) && (cmd_len != '0);
   assign last_byte = (cnt_q == len_q - 6'd1);

   always_comb begin
      state_d     = state_q;
      dest_d      = dest_q;
      len_d       = len_q;
      cnt_d       = cnt_q;
      par_d       = par_q;
      inj_d       = inj_q;
      pkt_valid_d = pkt_valid;
      data_out_d  = data_out;
      done_d      = 1'b0;
      cmd_err_d   = 1'b0;
      wr_en       = 1'b0;
      rd_addr     = '0;
      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               if (cmd_ok) begin
                  dest_d  = cmd_dest;
                  len_d   = cmd_len;
                  cnt_d   = '0;
                  par_d   = {cmd_len, cmd_dest};
`ifdef FRAMER_ERR_INJECT_EN
                  inj_d   = inject_err;
`else
                  inj_d   = 1'b0;
`endif
                  state_d = LOAD;
               end else begin
                  cmd_err_d = 1'b1;
               end
            end
         end
         LOAD: begin
            if (in_valid) begin
               wr_en = 1'b1;
               par_d = par_q ^ in_data;
               if (last_byte) begin
                  state_d     = HEADER;
                  cnt_d       = '0;
                  pkt_valid_d = 1'b1;
                  data_out_d  = {len_q, dest_q};
               end else begin
                  cnt_d = cnt_q + 6'd1;
               end
            end
         end
         HEADER: begin
            if (!busy) begin
               state_d    = PAYLOAD;
               data_out_d = rd_data;
            end
         end
         PAYLOAD: begin
            // cnt_q indexes the byte on the wire; prefetch the one after it
            rd_addr = cnt_q + 6'd1;
            if (!busy) begin
               if (last_byte) begin
                  state_d     = PARITY;
                  pkt_valid_d = 1'b0;
                  data_out_d  = par_q ^ {7'b0, inj_q};
               end else begin
                  cnt_d      = cnt_q + 6'd1;
                  data_out_d = rd_data;
               end
            end
         end
         PARITY: begin
            if (!busy) begin
               state_d    = IDLE;
               data_out_d = '0;
               done_d     = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= IDLE;
         dest_q    <= '0;
         len_q     <= '0;
         cnt_q     <= '0;
         par_q     <= '0;
         inj_q     <= 1'b0;
         pkt_valid <= 1'b0;
         data_out  <= '0;
         done      <= 1'b0;
         cmd_err   <= 1'b0;
      end else begin
         state_q   <= state_d;
         dest_q    <= dest_d;
         len_q     <= len_d;
         cnt_q     <= cnt_d;
         par_q     <= par_d;
         inj_q     <= inj_d;
         pkt_valid <= pkt_valid_d;
         data_out  <= data_out_d;
         done      <= done_d;
         cmd_err   <= cmd_err_d;
      end
   end

endmodule

// File: tb/tb_router_pkt_framer.sv
// Self-checking bench for router_pkt_framer: frame-level model plus literal stream checks.
module tb_router_pkt_framer;

   logic       clock = 1'b0;
   logic       reset;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_dest;
   logic [5:0] cmd_len;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;
   logic       busy;
`ifdef FRAMER_ERR_INJECT_EN
   logic       inject_err;
`endif
   logic       pkt_valid;
   logic [7:0] data_out;
   logic       done;
   logic       cmd_err;

   router_pkt_framer dut (
      .clock     (clock),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_dest  (cmd_dest),
      .cmd_len   (cmd_len),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .busy      (busy),
`ifdef FRAMER_ERR_INJECT_EN
      .inject_err(inject_err),
`endif
      .pkt_valid (pkt_valid),
      .data_out  (data_out),
      .done      (done),
      .cmd_err   (cmd_err)
   );

   always #5 clock = ~clock;

   int errors = 0;
   int checks = 0;

   // expected output values for the current cycle, updated just after each edge
   logic       check_en = 1'b0;
   logic       exp_pv, exp_done, exp_err, exp_cr, exp_ir;
   logic [7:0] exp_do;
   logic [7:0] got_q[$];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic set_idle();
      exp_pv = 1'b0; exp_do = 8'h00; exp_done = 1'b0;
      exp_err = 1'b0; exp_cr = 1'b1; exp_ir = 1'b0;
   endtask

   always @(negedge clock) begin
      if (check_en) begin
         chk("pkt_valid", {31'b0, pkt_valid}, {31'b0, exp_pv});
         chk("data_out",  {24'b0, data_out},  {24'b0, exp_do});
         chk("done",      {31'b0, done},      {31'b0, exp_done});
         chk("cmd_err",   {31'b0, cmd_err},   {31'b0, exp_err});
         chk("cmd_ready", {31'b0, cmd_ready}, {31'b0, exp_cr});
         chk("in_ready",  {31'b0, in_ready},  {31'b0, exp_ir});
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Sends one packet; frame = header, payload, parity. busy is raised stall_n edges while
   // frame byte stall_at is on the wire. abort_at >= 0 asserts reset while that byte shows.
   task automatic send_pkt(input logic [1:0] dest, input logic [5:0] len, input logic [7:0] pl[64],
                           input int stall_at, input int stall_n, input logic inj,
                           input logic gap, input int abort_at);
      logic [7:0] frame[66];
      logic [7:0] par;
      int j, left;
      par = {len, dest};
      frame[0] = par;
      for (int i = 0; i < int'(len); i++) begin
         frame[i+1] = pl[i];
         par ^= pl[i];
      end
      frame[int'(len)+1] = par ^ {7'b0, inj};

      cmd_valid = 1'b1; cmd_dest = dest; cmd_len = len;
`ifdef FRAMER_ERR_INJECT_EN
      inject_err = inj;
`endif
      tick();
      exp_cr = 1'b0; exp_ir = 1'b1;
      // junk request held during load/send must be ignored
      cmd_valid = 1'b1; cmd_dest = 2'd3; cmd_len = 6'd0;
      for (int i = 0; i < int'(len); i++) begin
         if (gap && i == 1) begin
            in_valid = 1'b0; in_data = 8'hFF;
            tick();
         end
         in_valid = 1'b1; in_data = pl[i];
         tick();
         if (i == int'(len) - 1) begin
            exp_ir = 1'b0; exp_pv = 1'b1; exp_do = frame[0];
         end
      end
      in_valid = 1'b1; in_data = 8'hA5;
      got_q.delete();
      got_q.push_back(data_out);
      j = 0; left = stall_n;
      while (j < int'(len) + 2) begin
         if (j == abort_at) begin
            reset = 1'b1; busy = 1'b0;
            tick();
            reset = 1'b0; cmd_valid = 1'b0; in_valid = 1'b0;
            set_idle();
            return;
         end
         busy = (j == stall_at) && (left > 0);
         if (j == int'(len) + 1) cmd_valid = 1'b0;
         tick();
         if (busy) begin
            left--;
         end else begin
            j++;
            if (j <= int'(len) + 1) begin
               exp_pv = (j <= int'(len));
               exp_do = frame[j];
               got_q.push_back(data_out);
            end else begin
               set_idle();
               exp_done = 1'b1;
            end
         end
      end
      busy = 1'b0; in_valid = 1'b0; cmd_valid = 1'b0;
      tick();
      exp_done = 1'b0;
   endtask

   task automatic chk_stream(input string name, input logic [7:0] exp[$]);
      chk({name, "_len"}, got_q.size(), exp.size());
      for (int i = 0; i < exp.size() && i < got_q.size(); i++)
         chk(name, {24'b0, got_q[i]}, {24'b0, exp[i]});
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1);
   end

   initial begin
      logic [7:0] pl[64];
      logic [7:0] e[$];
      reset = 1'b1; cmd_valid = 1'b0; cmd_dest = '0; cmd_len = '0;
      in_valid = 1'b0; in_data = '0; busy = 1'b0;
`ifdef FRAMER_ERR_INJECT_EN
      inject_err = 1'b0;
`endif
      for (int i = 0; i < 64; i++) pl[i] = 8'h00;
      tick(); tick();
      set_idle();
      check_en = 1'b1;
      reset = 1'b0;
      tick();

      // dest=0 len=1 payload 0x11
      pl[0] = 8'h11;
      send_pkt(2'd0, 6'd1, pl, -1, 0, 1'b0, 1'b0, -1);
      e = '{8'h04, 8'h11, 8'h15};
      chk_stream("t034", e);

      // dest=2 len=3, with an input gap
      pl[0] = 8'h33; pl[1] = 8'h44; pl[2] = 8'h55;
      send_pkt(2'd2, 6'd3, pl, -1, 0, 1'b0, 1'b1, -1);
      e = '{8'h0E, 8'h33, 8'h44, 8'h55, 8'h2C};
      chk_stream("t035", e);

      // same with busy held 2 cycles while 0x44 is on the wire
      send_pkt(2'd2, 6'd3, pl, 2, 2, 1'b0, 1'b0, -1);
      chk_stream("t036", e);

      // illegal requests
      cmd_valid = 1'b1; cmd_dest = 2'd3; cmd_len = 6'd2;
      tick();
      cmd_valid = 1'b0; exp_err = 1'b1;
      tick();
      exp_err = 1'b0;
      cmd_valid = 1'b1; cmd_dest = 2'd1; cmd_len = 6'd0;
      tick();
      cmd_valid = 1'b0; exp_err = 1'b1;
      tick();
      exp_err = 1'b0;
      tick();

      // full-length packet with stalls on header and last payload byte
      for (int i = 0; i < 64; i++) pl[i] = 8'($urandom_range(0, 255));
      send_pkt(2'd1, 6'd63, pl, 0, 1, 1'b0, 1'b0, -1);
      chk("t063_len", got_q.size(), 65);
      send_pkt(2'd2, 6'd63, pl, 63, 3, 1'b0, 1'b1, -1);

      // reset in the middle of a len=63 payload, then a fresh packet
      send_pkt(2'd0, 6'd63, pl, -1, 0, 1'b0, 1'b0, 20);
      tick();
      pl[0] = 8'h22;
      send_pkt(2'd1, 6'd1, pl, -1, 0, 1'b0, 1'b0, -1);
      e = '{8'h05, 8'h22, 8'h27};
      chk_stream("t038", e);

`ifdef FRAMER_ERR_INJECT_EN
      pl[0] = 8'h11;
      send_pkt(2'd0, 6'd1, pl, -1, 0, 1'b1, 1'b0, -1);
      e = '{8'h04, 8'h11, 8'h14};
      chk_stream("t039", e);
      inject_err = 1'b0;
`endif

      tick();
      check_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/router_pkt_framer.md
ROUTER_PKT_FRAMER -- requirements
Module: router_pkt_framer

Interface
REQ-001 SHALL have: clock  in  1  single clock, all logic on its rising edge.
REQ-002 SHALL have: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have: cmd_valid  in  1  packet request strobe.
REQ-004 SHALL have: cmd_ready  out  1  high only in IDLE.
REQ-005 SHALL have: cmd_dest  in  2  destination port, 0..2 legal.
REQ-006 SHALL have: cmd_len  in  6  payload byte count, 1..63 legal.
REQ-007 SHALL have: in_valid / in_data  in  1 / 8  payload byte stream.
REQ-008 SHALL have: in_ready  out  1  high only in LOAD.
REQ-009 SHALL have: busy  in  1  router backpressure; when high the presented byte is held.
REQ-010 SHALL have: pkt_valid  out  1  registered, drives router pkt_valid.
REQ-011 SHALL have: data_out  out  8  registered, drives router data_in.
REQ-012 SHALL have: done  out  1  one-cycle pulse, packet fully sent.
REQ-013 SHALL have: cmd_err  out  1  one-cycle pulse, illegal request rejected.

Function
REQ-014 SHALL implement states IDLE, LOAD, HEADER, PAYLOAD, PARITY.
REQ-015 IDLE: on cmd_valid with dest<=2 and len>=1, SHALL latch dest/len, clear byte count, set parity accumulator to {len,dest}, go LOAD.
REQ-016 IDLE: on cmd_valid with dest==3 or len==0, SHALL pulse cmd_err the next cycle and stay IDLE.
REQ-017 LOAD: each cycle with in_valid&in_ready SHALL write in_data to buffer[count], XOR it into parity, increment count.
REQ-018 LOAD: on the accepted byte where count==len-1, SHALL go HEADER on that edge; header visible the following cycle.
REQ-019 HEADER: SHALL present pkt_valid=1, data_out={len,dest}.
REQ-020 PAYLOAD: SHALL present pkt_valid=1, data_out=buffer[i], i=0..len-1 in order.
REQ-021 PARITY: SHALL present pkt_valid=0, data_out=accumulated parity (XOR of header and all payload bytes).
REQ-022 In HEADER/PAYLOAD/PARITY, an edge with busy=0 SHALL advance to the next byte; busy=1 SHALL hold state, data_out and pkt_valid unchanged.
REQ-023 With busy=0 throughout, transmission SHALL take exactly len+2 cycles.
REQ-024 Leaving PARITY with busy=0 SHALL return to IDLE, drive data_out=0x00, and pulse done for one cycle.
REQ-025 cmd_valid outside IDLE and in_valid outside LOAD SHALL be ignored.
REQ-026 Counters SHALL be 6 bits; len=63 SHALL complete without wrap-around corruption.

Reset
REQ-027 An edge with reset=1 SHALL force IDLE from any state, including mid-LOAD and mid-send.
REQ-028 After that edge: pkt_valid=0, data_out=0x00, done=0, cmd_err=0, in_ready=0, cmd_ready=1.
REQ-029 Buffer contents need not reset; the partial packet SHALL be discarded and never resumed.

Configuration
REQ-030 Macro FRAMER_ERR_INJECT_EN defined: SHALL add input inject_err (1 bit), latched with an accepted cmd; if set, transmitted parity byte SHALL be true parity ^ 0x01.
REQ-031 Macro undefined: inject_err port SHALL be absent; parity always correct.

Structure
REQ-032 Shared package router_pkg SHALL hold DEST_W=2, LEN_W=6, NUM_PORTS=3, DEST_INVALID=2'd3, MAX_LEN=63 and the framer state enum.
REQ-033 Payload storage SHALL be a sub-module framer_buf: 64x8, one synchronous write port, one read port, no reset.

Verification
REQ-034 dest=0, len=1, payload 0x11, busy=0 -> data_out 0x04,0x11,0x15; pkt_valid 1,1,0; done pulses once.
REQ-035 dest=2, len=3, payload 0x33,0x44,0x55 -> data_out 0x0E,0x33,0x44,0x55,0x2C; len+2=5 send cycles.
REQ-036 Repeat REQ-035 with busy=1 for 2 cycles during 0x44 -> 0x44 held 3 cycles; sequence and parity unchanged.
REQ-037 cmd dest=3,len=2 then dest=1,len=0 -> two cmd_err pulses, pkt_valid stays 0, cmd_ready stays 1.
REQ-038 reset=1 mid-PAYLOAD of a len=63 packet -> next cycle pkt_valid=0, data_out=0x00; following dest=1,len=1,0x22 packet emits 0x05,0x22,0x27.
REQ-039 With FRAMER_ERR_INJECT_EN, inject_err=1 on REQ-034 stimulus -> parity byte 0x14.
